// File: rtl/ras_commit_repair.sv
// ras_commit_repair: commit-side architectural return address stack with speculative RAS repair
//   Tracks retired calls/returns in a circular stack. On flush_i it pulses rs_clr_o to reset the
//   speculative RAS, then replays the architectural entries oldest first as valid/ready pushes.
//   Ports:
//     clk, rst_n                        clock, synchronous active-low reset
//     cmt_call_i, cmt_ret_i             retiring call (push) / return (pop)
//     cmt_target_i [29:0]               return address [31:2] of the retiring call
//     flush_i                           backend redirect, starts a restore
//     rs_clr_o                          one-cycle clear of the speculative RAS
//     rs_push_o, rs_target_o, rs_ready_i  restore push handshake and data
//     busy_o                            restore in progress
//     cmt_top_o, cmt_cnt_o              architectural top (0 when empty) and entry count
module ras_commit_repair #(
    parameter int STACK_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cmt_call_i,
    input  logic                             cmt_ret_i,
    input  logic [29:0]                      cmt_target_i,
    input  logic                             flush_i,
    output logic                             rs_clr_o,
    output logic                             rs_push_o,
    output logic [29:0]                      rs_target_o,
    input  logic                             rs_ready_i,
    output logic                             busy_o,
    output logic [29:0]                      cmt_top_o,
    output logic [$clog2(STACK_DEPTH+1)-1:0] cmt_cnt_o
);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam int CW = $clog2(STACK_DEPTH+1);
    localparam logic [AW-1:0] ONE_A = 1;
    localparam logic [CW-1:0] ONE_C = 1;
    localparam logic [CW-1:0] FULL = CW'(STACK_DEPTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] REPLAY = 2'd2;

    logic [29:0]   mem_q [STACK_DEPTH];
    logic [1:0]    state_q, state_d;
    logic [AW-1:0] head_q, head_d, rptr_q, rptr_d, waddr;
    logic [CW-1:0] cnt_q, cnt_d, rcnt_q, rcnt_d;
    logic          we;

    always_comb begin
        head_d  = head_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
        waddr   = head_q;
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rptr_d  = rptr_q;
        // Commit events are only seen while idle; commit is stalled during a restore.
        if (state_q == IDLE) begin
            if (cmt_call_i && cmt_ret_i && cnt_q != '0) begin
                we    = 1'b1;
                waddr = head_q - ONE_A;
            end else if (cmt_call_i) begin
                we     = 1'b1;
                head_d = head_q + ONE_A;
                cnt_d  = (cnt_q == FULL) ? cnt_q : cnt_q + ONE_C;
            end else if (cmt_ret_i && cnt_q != '0) begin
                head_d = head_q - ONE_A;
                cnt_d  = cnt_q - ONE_C;
            end
        end
        if (state_q == CLEAR) state_d = (rcnt_q == '0) ? IDLE : REPLAY;
        if (state_q == REPLAY && rs_ready_i) begin
            rptr_d = rptr_q + ONE_A;
            rcnt_d = rcnt_q - ONE_C;
            if (rcnt_q == ONE_C) state_d = IDLE;
        end
        // A flush in any state restarts from a snapshot of the post-event stack.
        if (flush_i) begin
            state_d = CLEAR;
            rcnt_d  = cnt_d;
            rptr_d  = head_d - AW'(cnt_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            head_q  <= '0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            rptr_q  <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && we) mem_q[waddr] <= cmt_target_i;
    end

    assign rs_clr_o    = state_q == CLEAR;
    assign rs_push_o   = state_q == REPLAY;
    assign busy_o      = state_q != IDLE;
    assign rs_target_o = rs_push_o ? mem_q[rptr_q] : 30'd0;
    assign cmt_top_o   = (cnt_q != '0) ? mem_q[head_q - ONE_A] : 30'd0;
    assign cmt_cnt_o   = cnt_q;
endmodule

// File: tb/tb_ras_commit_repair.sv
// tb_ras_commit_repair: directed self-checking bench for ras_commit_repair (depth 8 and depth 2)
module tb_ras_commit_repair;
    logic        clk = 1'b0;
    logic        rst_n, cmt_call, cmt_ret, flush, rs_ready;
    logic [29:0] cmt_target;
    logic        a_clr, a_push, a_busy, b_clr, b_push, b_busy;
    logic [29:0] a_target, a_top, b_target, b_top;
    logic [3:0]  a_cnt;
    logic [1:0]  b_cnt;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    ras_commit_repair #(.STACK_DEPTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .cmt_call_i(cmt_call), .cmt_ret_i(cmt_ret),
        .cmt_target_i(cmt_target), .flush_i(flush), .rs_clr_o(a_clr), .rs_push_o(a_push),
        .rs_target_o(a_target), .rs_ready_i(rs_ready), .busy_o(a_busy),
        .cmt_top_o(a_top), .cmt_cnt_o(a_cnt)
    );

    ras_commit_repair #(.STACK_DEPTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmt_call_i(cmt_call), .cmt_ret_i(cmt_ret),
        .cmt_target_i(cmt_target), .flush_i(flush), .rs_clr_o(b_clr), .rs_push_o(b_push),
        .rs_target_o(b_target), .rs_ready_i(rs_ready), .busy_o(b_busy),
        .cmt_top_o(b_top), .cmt_cnt_o(b_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cmt_call = 1'b0; cmt_ret = 1'b0; flush = 1'b0;
        rs_ready = 1'b1; cmt_target = '0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic call(input logic [29:0] t);
        cmt_call = 1'b1; cmt_target = t;
        step();
        cmt_call = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (a_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt act=%0d exp=0", a_cnt); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy act=%b exp=0", a_busy); end
        checks++; if (a_clr !== 1'b0) begin errors++; $display("FAIL reset_clr act=%b exp=0", a_clr); end
        checks++; if (a_push !== 1'b0) begin errors++; $display("FAIL reset_push act=%b exp=0", a_push); end
        checks++; if (a_top !== 30'd0) begin errors++; $display("FAIL reset_top act=%h exp=0", a_top); end
    endtask

    task automatic test_basic();
        do_reset();
        call(30'h100); call(30'h200); call(30'h300);
        cmt_ret = 1'b1; step(); cmt_ret = 1'b0;
        checks++; if (a_cnt !== 4'd2) begin errors++; $display("FAIL basic_cnt act=%0d exp=2", a_cnt); end
        checks++; if (a_top !== 30'h200) begin errors++; $display("FAIL basic_top act=%h exp=200", a_top); end
        flush = 1'b1; step(); flush = 1'b0;
        checks++; if ({a_clr, a_push, a_busy} !== 3'b101) begin errors++; $display("FAIL basic_clr act=%b exp=101", {a_clr, a_push, a_busy}); end
        step();
        checks++; if ({a_clr, a_push, a_busy} !== 3'b011 || a_target !== 30'h100) begin errors++; $display("FAIL basic_push0 act=%b/%h exp=011/100", {a_clr, a_push, a_busy}, a_target); end
        step();
        checks++; if ({a_clr, a_push, a_busy} !== 3'b011 || a_target !== 30'h200) begin errors++; $display("FAIL basic_push1 act=%b/%h exp=011/200", {a_clr, a_push, a_busy}, a_target); end
        step();
        checks++; if ({a_clr, a_push, a_busy} !== 3'b000) begin errors++; $display("FAIL basic_done act=%b exp=000", {a_clr, a_push, a_busy}); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) call(30'h10 + 30'(i));
        checks++; if (a_cnt !== 4'd8) begin errors++; $display("FAIL ovf_cnt act=%0d exp=8", a_cnt); end
        checks++; if (a_top !== 30'h19) begin errors++; $display("FAIL ovf_top act=%h exp=19", a_top); end
        flush = 1'b1; step(); flush = 1'b0;
        checks++; if (a_clr !== 1'b1) begin errors++; $display("FAIL ovf_clr act=%b exp=1", a_clr); end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (a_push !== 1'b1 || a_target !== 30'h12 + 30'(i)) begin errors++; $display("FAIL ovf_push%0d act=%b/%h exp=1/%h", i, a_push, a_target, 30'h12 + 30'(i)); end
        end
        step();
        checks++; if (a_busy !== 1'b0 || a_push !== 1'b0) begin errors++; $display("FAIL ovf_done act=%b%b exp=00", a_busy, a_push); end
    endtask

    task automatic test_empty();
        do_reset();
        cmt_ret = 1'b1; step(); cmt_ret = 1'b0;
        checks++; if (a_cnt !== 4'd0 || a_top !== 30'd0) begin errors++; $display("FAIL empty_ret act=%0d/%h exp=0/0", a_cnt, a_top); end
        flush = 1'b1; step(); flush = 1'b0;
        checks++; if ({a_clr, a_push, a_busy} !== 3'b101) begin errors++; $display("FAIL empty_clr act=%b exp=101", {a_clr, a_push, a_busy}); end
        step();
        checks++; if ({a_clr, a_push, a_busy} !== 3'b000) begin errors++; $display("FAIL empty_done act=%b exp=000", {a_clr, a_push, a_busy}); end
    endtask

    task automatic test_stall();
        do_reset();
        call(30'h40); call(30'h50);
        checks++; if (b_cnt !== 2'd2 || b_top !== 30'h50) begin errors++; $display("FAIL stall_fill act=%0d/%h exp=2/50", b_cnt, b_top); end
        flush = 1'b1; rs_ready = 1'b0; step(); flush = 1'b0;
        checks++; if (b_clr !== 1'b1 || b_push !== 1'b0) begin errors++; $display("FAIL stall_clr act=%b%b exp=10", b_clr, b_push); end
        cmt_call = 1'b1; cmt_target = 30'h77;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (b_push !== 1'b1 || b_target !== 30'h40) begin errors++; $display("FAIL stall_hold%0d act=%b/%h exp=1/40", i, b_push, b_target); end
        end
        cmt_call = 1'b0;
        checks++; if (b_cnt !== 2'd2 || b_top !== 30'h50) begin errors++; $display("FAIL stall_drop act=%0d/%h exp=2/50", b_cnt, b_top); end
        rs_ready = 1'b1; step();
        checks++; if (b_push !== 1'b1 || b_target !== 30'h50) begin errors++; $display("FAIL stall_push1 act=%b/%h exp=1/50", b_push, b_target); end
        step();
        checks++; if (b_busy !== 1'b0 || b_push !== 1'b0) begin errors++; $display("FAIL stall_done act=%b%b exp=00", b_busy, b_push); end
    endtask

    task automatic test_restart();
        cmt_call = 1'b1; cmt_ret = 1'b1; cmt_target = 30'h60; flush = 1'b1;
        step();
        cmt_call = 1'b0; cmt_ret = 1'b0; flush = 1'b0;
        checks++; if (b_top !== 30'h60 || b_cnt !== 2'd2) begin errors++; $display("FAIL rst_replace act=%h/%0d exp=60/2", b_top, b_cnt); end
        checks++; if (b_clr !== 1'b1) begin errors++; $display("FAIL rst_clr0 act=%b exp=1", b_clr); end
        step();
        checks++; if (b_push !== 1'b1 || b_target !== 30'h40) begin errors++; $display("FAIL rst_push0 act=%b/%h exp=1/40", b_push, b_target); end
        flush = 1'b1; step(); flush = 1'b0;
        checks++; if (b_clr !== 1'b1 || b_push !== 1'b0 || b_busy !== 1'b1) begin errors++; $display("FAIL rst_reclr act=%b%b%b exp=101", b_clr, b_push, b_busy); end
        step();
        checks++; if (b_push !== 1'b1 || b_target !== 30'h40) begin errors++; $display("FAIL rst_again0 act=%b/%h exp=1/40", b_push, b_target); end
        step();
        checks++; if (b_push !== 1'b1 || b_target !== 30'h60) begin errors++; $display("FAIL rst_again1 act=%b/%h exp=1/60", b_push, b_target); end
        step();
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL rst_done act=%b exp=0", b_busy); end
        flush = 1'b1; step(); flush = 1'b0;
        step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        checks++; if ({b_clr, b_push, b_busy} !== 3'b000 || b_cnt !== 2'd0) begin errors++; $display("FAIL midreset act=%b/%0d exp=000/0", {b_clr, b_push, b_busy}, b_cnt); end
        step();
        checks++; if ({b_clr, b_push, b_busy} !== 3'b000) begin errors++; $display("FAIL midreset_quiet act=%b exp=000", {b_clr, b_push, b_busy}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_empty();
        test_stall();
        test_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
